square_bouncer: RTL and testbench
=================================

# square_bouncer

Animated paint stage between the 640x480 display timing generator and the VGA pins. It consumes the pixel coordinates, data-enable and syncs, and keeps a square's position registered. Once per frame it moves the square diagonally, bouncing off the screen edges. It drives the registered 4-bit RGB and sync outputs with the syncs delay-matched to the colour path.

## Interface
- CORDW, 10, screen coordinate width in bits
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- SQ_SIZE, 200, square edge length in pixels
- SPEED, 1, pixels moved per frame on each axis (1..15)
- SQ_X0, 220, reset x of square's left edge
- SQ_Y0, 140, reset y of square's top edge

Ports:
- clk_pix  in  1  pixel clock; one clock domain only
- rst_pix  in  1  reset, asynchronous, active-high
- sx  in  CORDW  current pixel x from timing generator
- sy  in  CORDW  current line y from timing generator
- de  in  1  data enable; high in the active area
- hsync  in  1  horizontal sync, active-low
- vsync  in  1  vertical sync, active-low
- vga_hsync  out  1  delayed hsync
- vga_vsync  out  1  delayed vsync
- vga_r, vga_g, vga_b  out  4 each  pixel colour

## Operation
- **Reset values.**
  - vga_r/g/b = 0; vga_hsync = vga_vsync = 1 (inactive).
  - qx = SQ_X0, qy = SQ_Y0; dir_x = dir_y = positive.
  - Pipeline registers and the colour index are cleared.
- **Frame tick.** frame_tick is a 1-cycle pulse when sx == 0 and sy == V_RES, i.e. the first blanking line. Exactly one tick occurs per frame.
- **Axis update on frame_tick**, applied independently to x (limit H_RES) and y (limit V_RES):
  - Positive direction and pos + SQ_SIZE + SPEED >= limit: pos <= limit − SQ_SIZE, direction flips to negative, axis bounce asserted.
  - Negative direction and pos <= SPEED: pos <= 0, direction flips to positive, axis bounce asserted.
  - Otherwise: pos ± SPEED.
- **Arithmetic.** All position sums and compares are done in CORDW+1 bits, so pos + SQ_SIZE never wraps.
- **Hit test.** square = (sx >= qx) && (sx < qx + SQ_SIZE) && (sy >= qy) && (sy < qy + SQ_SIZE).
- **Colour.**
  - de low: 0/0/0.
  - de high, inside square: the square colour.
  - de high, outside square: background 1/3/7.
- **Position stability.** Position changes only during vertical blanking, so no frame shows a torn square.
- **Reset mid-frame.** All state returns to reset values immediately. The next frame_tick resumes motion from SQ_X0/SQ_Y0.

## Timing
- Stage 1 registers: square hit, de, hsync, vsync.
- Stage 2 registers: the colour mux result and the syncs onto the outputs.
- Latency is 2 clk_pix from inputs to every output. Colour and syncs stay aligned.
- A position update is visible to the hit test the cycle after frame_tick.
- Throughput: one pixel per clock, no stalls.

## Configuration
- SQUARE_COLOUR_CYCLE_EN defined:
  - A 2-bit colour index increments once per frame_tick on which either axis bounces. A simultaneous x and y bounce (corner hit) counts as one increment.
  - Palette: 0 = F/F/F, 1 = F/0/0, 2 = 0/F/0, 3 = 0/0/F. The index wraps 3 -> 0.
- Not defined: the square is always F/F/F, and no index register exists.

## Structure
- display_pkg holds CORDW, H_RES, V_RES, the background colour constants and the 4-entry palette.
- Sub-module bounce_axis holds one position register and one direction flag. Its inputs are frame_tick, limit, SQ_SIZE and SPEED; its outputs are pos and bounce. It is instantiated twice (x and y).
- The top level holds the frame-tick decode, the hit test, the 2-stage pipeline and the optional colour index.

## Test plan
- Reset, then sx = 300, sy = 200, de = 1 -> 2 cycles later RGB = F/F/F; with sx = 10 -> RGB = 1/3/7.
- de = 0 inside the square -> RGB = 0/0/0. hsync pulse of 96 cycles -> vga_hsync pulse of 96 cycles, delayed exactly 2.
- One frame_tick -> qx = 221, qy = 141. Frame_tick at sx = 0, sy = V_RES only; none at sy = V_RES, sx = 1.
- 220 frame_ticks from reset -> qx = 440 with dir_x flipped to negative. The next tick gives qx = 439.
- Corner case SQ_X0 = 440, SQ_Y0 = 280 -> both axes bounce on the first tick. With SQUARE_COLOUR_CYCLE_EN the colour index goes 0 -> 1 (once), and the square renders F/0/0.
- Assert rst_pix mid-line after 50 ticks -> outputs go to reset values asynchronously, and qx/qy return to 220/140.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared 640x480 display geometry and colour constants.
package display_pkg;
  localparam int CORDW = 10;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam logic [11:0] BG_COLOUR = 12'h137;
  localparam logic [11:0] PALETTE [4] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F};
endpackage

// File: rtl/bounce_axis.sv
// bounce_axis: one axis of the square's position, stepped and bounced on each frame tick.
module bounce_axis #(
  parameter int CORDW   = 10,
  parameter int SQ_SIZE = 200,
  parameter int SPEED   = 1,
  parameter int POS0    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [CORDW-1:0] limit,
  output logic [CORDW-1:0] pos,
  output logic             bounce
);
  localparam int W = CORDW + 1;
  logic [CORDW-1:0] pos_q, pos_d;
  logic neg_q, neg_d, hit_hi, hit_lo;
  logic [W-1:0] p, lim, sz, sp;
  // One spare bit keeps pos + SQ_SIZE + SPEED from wrapping near the far edge.
  always_comb begin
    p      = {1'b0, pos_q};
    lim    = {1'b0, limit};
    sz     = W'(SQ_SIZE);
    sp     = W'(SPEED);
    hit_hi = !neg_q && (p + sz + sp >= lim);
    hit_lo = neg_q && (p <= sp);
    bounce = frame_tick && (hit_hi || hit_lo);
    neg_d  = bounce ? !neg_q : neg_q;
    pos_d  = !frame_tick ? pos_q :
             hit_hi      ? CORDW'(lim - sz) :
             hit_lo      ? '0 :
             neg_q       ? pos_q - CORDW'(SPEED) : pos_q + CORDW'(SPEED);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= CORDW'(POS0);
      neg_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      neg_q <= neg_d;
    end
  end
  assign pos = pos_q;
endmodule

// File: rtl/square_bouncer.sv
// square_bouncer: paints a bouncing square over a background, 2-cycle pipeline to the VGA pins.
// Optional SQUARE_COLOUR_CYCLE_EN steps the square through a 4-colour palette on each bounce.
module square_bouncer
  import display_pkg::*;
#(
  parameter int SQ_SIZE = 200,
  parameter int SPEED   = 1,
  parameter int SQ_X0   = 220,
  parameter int SQ_Y0   = 140
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             hsync,
  input  logic             vsync,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b
);
  localparam int W = CORDW + 1;
  logic [CORDW-1:0] qx, qy;
  logic frame_tick, bx, by, in_sq;
  logic hit_q, hit_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d, vhs_q, vhs_d, vvs_q, vvs_d;
  logic [11:0] rgb_q, rgb_d, sq_col;
  bounce_axis #(.CORDW(CORDW), .SQ_SIZE(SQ_SIZE), .SPEED(SPEED), .POS0(SQ_X0)) u_x (
    .clk(clk_pix), .rst(rst_pix), .frame_tick(frame_tick), .limit(CORDW'(H_RES)),
    .pos(qx), .bounce(bx)
  );
  bounce_axis #(.CORDW(CORDW), .SQ_SIZE(SQ_SIZE), .SPEED(SPEED), .POS0(SQ_Y0)) u_y (
    .clk(clk_pix), .rst(rst_pix), .frame_tick(frame_tick), .limit(CORDW'(V_RES)),
    .pos(qy), .bounce(by)
  );
`ifdef SQUARE_COLOUR_CYCLE_EN
  logic [1:0] cidx_q, cidx_d;
  assign cidx_d = cidx_q + 2'(bx | by);
  assign sq_col = PALETTE[cidx_q];
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) cidx_q <= '0;
    else         cidx_q <= cidx_d;
  end
`else
  logic unused_bounce;
  assign unused_bounce = bx | by;
  assign sq_col = PALETTE[0];
`endif
  // First blanking line start: position only moves while nothing is being drawn.
  assign frame_tick = (sx == '0) && (sy == CORDW'(V_RES));
  always_comb begin
    in_sq = ({1'b0, sx} >= {1'b0, qx}) && ({1'b0, sx} < {1'b0, qx} + W'(SQ_SIZE)) &&
            ({1'b0, sy} >= {1'b0, qy}) && ({1'b0, sy} < {1'b0, qy} + W'(SQ_SIZE));
    hit_d = in_sq;
    de_d  = de;
    hs_d  = hsync;
    vs_d  = vsync;
    rgb_d = !de_q ? 12'h000 : hit_q ? sq_col : BG_COLOUR;
    vhs_d = hs_q;
    vvs_d = vs_q;
  end
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      hit_q <= 1'b0;
      de_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
      vhs_q <= 1'b1;
      vvs_q <= 1'b1;
    end else begin
      hit_q <= hit_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
      vhs_q <= vhs_d;
      vvs_q <= vvs_d;
    end
  end
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hsync = vhs_q;
  assign vga_vsync = vvs_q;
endmodule

// File: tb/tb_square_bouncer.sv
// tb_square_bouncer: directed checks of colour, sync delay and bounce motion for square_bouncer.
module tb_square_bouncer;
  logic clk_pix = 1'b0;
  logic rst_pix;
  logic [9:0] sx, sy;
  logic de, hsync, vsync;
  logic vga_hsync, vga_vsync, c_hsync, c_vsync;
  logic [3:0] vga_r, vga_g, vga_b, c_r, c_g, c_b;
  int checks = 0;
  int errors = 0;
  int first_low, low_cnt;

  square_bouncer dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de), .hsync(hsync), .vsync(vsync),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );
  square_bouncer #(.SQ_X0(440), .SQ_Y0(280)) corner (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de), .hsync(hsync), .vsync(vsync),
    .vga_hsync(c_hsync), .vga_vsync(c_vsync), .vga_r(c_r), .vga_g(c_g), .vga_b(c_b)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_pix);
    #1;
  endtask

  task automatic tick();
    sx = 10'd0; sy = 10'd480; de = 1'b0;
    step(1);
    sx = 10'd1;
    step(1);
  endtask

  initial begin
    rst_pix = 1'b1; sx = '0; sy = '0; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
    #1;
    check("reset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    check("reset_syncs", {vga_hsync, vga_vsync}, 2'b11);
    check("reset_qx", dut.qx, 220);
    check("reset_qy", dut.qy, 140);
    step(2);
    rst_pix = 1'b0;
    step(1);
    sx = 10'd300; sy = 10'd200; de = 1'b1;
    step(1);
    check("latency_not_early", {vga_r, vga_g, vga_b}, 12'h000);
    step(1);
    check("inside_white", {vga_r, vga_g, vga_b}, 12'hFFF);
    sx = 10'd10;
    step(2);
    check("outside_bg", {vga_r, vga_g, vga_b}, 12'h137);
    sx = 10'd300; de = 1'b0;
    step(2);
    check("blank_black", {vga_r, vga_g, vga_b}, 12'h000);
    first_low = -1; low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      hsync = !(i < 96);
      step(1);
      if (!vga_hsync) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
    end
    check("hsync_delay", first_low, 1);
    check("hsync_width", low_cnt, 96);
    check("vsync_idle", vga_vsync, 1'b1);
    sx = 10'd1; sy = 10'd480;
    step(1);
    check("no_tick_sx1_qx", dut.qx, 220);
    tick();
    check("tick1_qx", dut.qx, 221);
    check("tick1_qy", dut.qy, 141);
    check("corner_qx", corner.qx, 440);
    check("corner_qy", corner.qy, 280);
    check("corner_dirs", {corner.u_x.neg_q, corner.u_y.neg_q}, 2'b11);
`ifdef SQUARE_COLOUR_CYCLE_EN
    check("corner_cidx", corner.cidx_q, 1);
`endif
    sx = 10'd500; sy = 10'd300; de = 1'b1;
    step(2);
`ifdef SQUARE_COLOUR_CYCLE_EN
    check("corner_colour", {c_r, c_g, c_b}, 12'hF00);
`else
    check("corner_colour", {c_r, c_g, c_b}, 12'hFFF);
`endif
    check("moved_sq_bg", {vga_r, vga_g, vga_b}, 12'h137);
    for (int i = 0; i < 218; i++) tick();
    check("tick219_qx", dut.qx, 439);
    check("tick219_dirx", dut.u_x.neg_q, 1'b0);
    tick();
    check("tick220_qx", dut.qx, 440);
    check("tick220_dirx", dut.u_x.neg_q, 1'b1);
    check("tick220_qy", dut.qy, 200);
    tick();
    check("tick221_qx", dut.qx, 439);
    check("tick221_qy", dut.qy, 199);
    sx = 10'd300; sy = 10'd200; de = 1'b1;
    step(2);
    check("pre_reset_bg", {vga_r, vga_g, vga_b}, 12'h137);
    hsync = 1'b0;
    step(2);
    #2;
    rst_pix = 1'b1;
    #1;
    check("async_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    check("async_hsync", vga_hsync, 1'b1);
    check("async_qx", dut.qx, 220);
    check("async_qy", dut.qy, 140);
    hsync = 1'b1;
    step(1);
    rst_pix = 1'b0;
    tick();
    check("resume_qx", dut.qx, 221);
    check("resume_qy", dut.qy, 141);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
